sodor_rand_instr_gen: RTL and testbench

//  Synthesizable, seeded random RV32I instruction source for sodor5 model-vs-core equivalence runs.

---
 rtl/sodor_rand_instr_gen.sv | 117 +++++++++++
 tb/tb_sodor_rand_instr_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sodor_rand_instr_gen.sv
// Seeded LFSR-driven RV32I instruction source (I-type ALU and loads) with valid/ready handshake.
// Optional macro SODOR_GEN_RTYPE_EN adds R-type ALU instructions when lfsr[31:30] == 2'b11.
module sodor_rand_instr_gen #(
  parameter logic [31:0] SEED          = 32'd157,
  parameter int          NUM_REGS      = 32,
  parameter int          LOAD_WEIGHT   = 8,
  parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF,
  parameter logic [31:0] NUM_INSTRS    = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_instr_count,
  output logic        o_done
);

  localparam logic [31:0] SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [4:0]  REG_MASK   = 5'(NUM_REGS - 1);
  localparam logic [4:0]  LOAD_LIMIT = 5'(LOAD_WEIGHT);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_lfsr;
  logic [31:0] r_count;
  logic        r_valid;
  logic        r_done;

  logic [31:0] w_lfsrNext;
  logic [31:0] w_countNext;
  logic        w_handshake;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [11:0] w_aluImm;
  logic [31:0] w_genWord;

  assign w_lfsrNext  = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_countNext = r_count + 32'd1;
  assign w_handshake = r_valid & i_instr_ready;
  assign w_rs1       = r_lfsr[16:12] & REG_MASK;
  assign w_rd        = r_lfsr[24:20] & REG_MASK;
  assign w_f3        = r_lfsr[19:17];

`ifdef SODOR_GEN_RTYPE_EN
  logic [4:0] w_rs2;
  logic [6:0] w_f7;
  assign w_rs2 = r_lfsr[4:0] & REG_MASK;
  assign w_f7  = (r_lfsr[5] && (w_f3 == 3'd0 || w_f3 == 3'd5)) ? 7'h20 : 7'h00;
`endif

  // The word is decoded from the current LFSR state, so it holds while stalled.
  always_comb begin
    case (w_f3)
      3'd1:    w_aluImm = r_lfsr[11:0] & 12'h01F;
      3'd5:    w_aluImm = r_lfsr[11:0] & 12'h41F;
      default: w_aluImm = r_lfsr[11:0];
    endcase
    w_genWord = {w_aluImm, w_rs1, w_f3, w_rd, 7'b0010011};
    if ({1'b0, r_lfsr[29:26]} < LOAD_LIMIT) begin
      w_genWord = {r_lfsr[11:0] & LOAD_IMM_MASK, w_rs1, r_lfsr[25], 2'b00, w_rd, 7'b0000011};
    end
`ifdef SODOR_GEN_RTYPE_EN
    if (r_lfsr[31:30] == 2'b11) begin
      w_genWord = {w_f7, w_rs2, w_rs1, w_f3, w_rd, 7'b0110011};
    end
`endif
  end

  assign o_instr       = (r_state == RUN) ? w_genWord : NOP;
  assign o_instr_valid = r_valid;
  assign o_instr_count = r_count;
  assign o_done        = r_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_lfsr  <= SEED_EFF;
      r_count <= 32'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_valid <= 1'b1;
          end
        end
        RUN: begin
          if (w_handshake) begin
            r_lfsr  <= w_lfsrNext;
            r_count <= w_countNext;
            if (NUM_INSTRS != 32'd0 && w_countNext == NUM_INSTRS) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sodor_rand_instr_gen.sv
// Directed bench for sodor_rand_instr_gen: two instances (bounded loads+ALU, unbounded ALU-only)
// checked against a bench-side LFSR/decode model through expected-word queues.
module tb_sodor_rand_instr_gen;

  logic        clk = 1'b0;
  logic        reset0, start0, ready0, valid0, done0;
  logic        reset1, start1, ready1, valid1, done1;
  logic [31:0] instr0, count0, instr1, count1;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] m0, m1;

  always #5 clk = ~clk;

  sodor_rand_instr_gen #(
    .SEED(32'd0), .NUM_REGS(32), .LOAD_WEIGHT(8), .LOAD_IMM_MASK(12'hFFF), .NUM_INSTRS(32'd4)
  ) dut0 (
    .i_clk(clk), .i_reset(reset0), .i_start(start0), .i_instr_ready(ready0),
    .o_instr(instr0), .o_instr_valid(valid0), .o_instr_count(count0), .o_done(done0)
  );

  sodor_rand_instr_gen #(
    .SEED(32'h0002_0FFF), .NUM_REGS(32), .LOAD_WEIGHT(0), .LOAD_IMM_MASK(12'hFFF), .NUM_INSTRS(32'd0)
  ) dut1 (
    .i_clk(clk), .i_reset(reset1), .i_start(start1), .i_instr_ready(ready1),
    .o_instr(instr1), .o_instr_valid(valid1), .o_instr_count(count1), .o_done(done1)
  );

  function automatic logic [31:0] modelNext(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] modelWord(input logic [31:0] s, input int lw);
    logic [2:0]  f3;
    logic [11:0] imm;
    f3  = s[19:17];
    imm = s[11:0];
    if (int'(s[29:26]) < lw) return {imm, s[16:12], s[25], 2'b00, s[24:20], 7'b0000011};
    if (f3 == 3'd1) imm = imm & 12'h01F;
    if (f3 == 3'd5) imm = imm & 12'h41F;
    return {imm, s[16:12], f3, s[24:20], 7'b0010011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle0(input string tag);
    checkOutput({tag, " instr0"}, instr0, 32'h0000_0013);
    checkOutput({tag, " valid0"}, 32'(valid0), 32'd0);
    checkOutput({tag, " count0"}, count0, 32'd0);
    checkOutput({tag, " done0"}, 32'(done0), 32'd0);
  endtask

  task automatic checkIdle1(input string tag);
    checkOutput({tag, " instr1"}, instr1, 32'h0000_0013);
    checkOutput({tag, " valid1"}, 32'(valid1), 32'd0);
    checkOutput({tag, " count1"}, count1, 32'd0);
    checkOutput({tag, " done1"}, 32'(done1), 32'd0);
  endtask

  task automatic popCheck0(input string tag);
    if (q0.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=%h expected=<empty queue>", tag, instr0);
    end else begin
      checkOutput(tag, instr0, q0.pop_front());
    end
  endtask

  task automatic popCheck1(input string tag);
    if (q1.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=%h expected=<empty queue>", tag, instr1);
    end else begin
      checkOutput(tag, instr1, q1.pop_front());
    end
  endtask

  initial begin
    reset0 = 1'b1; start0 = 1'b0; ready0 = 1'b0;
    reset1 = 1'b1; start1 = 1'b0; ready1 = 1'b0;

    repeat (5) begin
      tick();
      checkIdle0("T1");
      checkIdle1("T1");
    end

    // Bounded run on dut0: four handshakes, then sticky DONE.
    reset0 = 1'b0;
    tick();
    m0 = 32'd1;
    ready0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    q0.push_back(modelWord(m0, 8));
    checkOutput("T2 first word", instr0, 32'h0010_0003);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("T5 valid", 32'(valid0), 32'd1);
      popCheck0("T5 word");
      tick();
      m0 = modelNext(m0);
      checkOutput("T5 count", count0, 32'(k));
      if (k < 4) q0.push_back(modelWord(m0, 8));
    end
    checkOutput("T5 done", 32'(done0), 32'd1);
    checkOutput("T5 valid low", 32'(valid0), 32'd0);
    checkOutput("T5 nop", instr0, 32'h0000_0013);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    checkOutput("T5 start ignored done", 32'(done0), 32'd1);
    checkOutput("T5 start ignored valid", 32'(valid0), 32'd0);
    checkOutput("T5 start ignored count", count0, 32'd4);

    // dut1: stall four cycles, then stream.
    reset1 = 1'b0;
    m1 = 32'h0002_0FFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    q1.push_back(modelWord(m1, 0));
    checkOutput("T3 slli word", instr1, 32'h01F0_1013);
    repeat (4) begin
      checkOutput("T4 hold instr", instr1, 32'h01F0_1013);
      checkOutput("T4 hold valid", 32'(valid1), 32'd1);
      checkOutput("T4 hold count", count1, 32'd0);
      tick();
    end
    ready1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      popCheck1("T4 word");
      tick();
      m1 = modelNext(m1);
      checkOutput("T4 count", count1, 32'(k));
      q1.push_back(modelWord(m1, 0));
    end
    popCheck1("T4 last word");
    checkOutput("T4 not done", 32'(done1), 32'd0);

    // Mid-run reset on dut0 at count 2.
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    q0.delete();
    m0 = 32'd1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    q0.push_back(modelWord(m0, 8));
    for (int k = 1; k <= 2; k++) begin
      popCheck0("T6 word");
      tick();
      m0 = modelNext(m0);
      q0.push_back(modelWord(m0, 8));
    end
    checkOutput("T6 count before reset", count0, 32'd2);
    reset0 = 1'b1;
    tick();
    checkIdle0("T6 after reset");
    start0 = 1'b1;
    tick();
    checkIdle0("T6 reset beats start");
    reset0 = 1'b0;
    tick();
    start0 = 1'b0;
    checkOutput("T6 restart word", instr0, 32'h0010_0003);
    checkOutput("T6 restart valid", 32'(valid0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
